// File: rtl/gain_oot_cmd_sched.sv
// gain_oot_cmd_sched
//   Gain command scheduler for the gain_oot block. Holds a FIFO of timed gain commands
//   ({timestamp, gain}) written over ctrlport and releases each one onto o_gain when the
//   datapath strobes a sample time >= the command timestamp. Immediate gain writes bypass
//   the queue.
//
// Ports
//   ce_clk, ce_rst          block clock, asynchronous active-high reset
//   s_ctrlport_req_*        register request (wr/rd strobes, byte address, write data)
//   s_ctrlport_resp_*       response ack pulse and read data (valid with ack)
//   i_time, i_time_stb      timestamp of the sample the datapath is accepting
//   o_gain, o_gain_upd      active gain and a 1-cycle pulse whenever it is written
module gain_oot_cmd_sched #(
   parameter logic [19:0]       BASE_ADDR = 20'h0,
   parameter int unsigned       GAIN_W    = 16,
   parameter logic [GAIN_W-1:0] GAIN_INIT = 16'h1,
   parameter int unsigned       FIFO_AW   = 3
) (
   input  logic              ce_clk,
   input  logic              ce_rst,
   input  logic              s_ctrlport_req_wr,
   input  logic              s_ctrlport_req_rd,
   input  logic [19:0]       s_ctrlport_req_addr,
   input  logic [31:0]       s_ctrlport_req_data,
   output logic              s_ctrlport_resp_ack,
   output logic [31:0]       s_ctrlport_resp_data,
   input  logic [63:0]       i_time,
   input  logic              i_time_stb,
   output logic [GAIN_W-1:0] o_gain,
   output logic              o_gain_upd
);

   localparam int unsigned DEPTH = 2 ** FIFO_AW;
   localparam int unsigned CW    = FIFO_AW + 1;
   localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]      CNT_FULL = CW'(DEPTH);
   localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

   logic [63:0]       r_ts_mem   [DEPTH];
   logic [GAIN_W-1:0] r_gain_mem [DEPTH];
   logic [FIFO_AW-1:0] r_rd_ptr, r_wr_ptr;
   logic [CW-1:0]      r_count;
   logic [63:0]        r_ts_stage;
   logic               r_overflow;
   logic [7:0]         r_late;
   logic [GAIN_W-1:0]  r_gain;
   logic               r_gain_upd;
   logic               r_ack;
   logic [31:0]        r_rdata;

   logic [20:0] w_off_full;
   logic        w_in_win;
   logic [4:0]  w_off;
   logic        w_wr, w_rd;
   logic        w_wr_gain, w_wr_tslo, w_wr_tshi, w_push, w_wr_stat;
   logic        w_flush, w_clr;
   logic        w_empty, w_full;
   logic [63:0] w_head_ts;
   logic [GAIN_W-1:0] w_head_gain;
   logic        w_due, w_pop, w_push_ok, w_late;
   logic [31:0] w_status, w_rdata;

   // Borrow into bit 20 flags addresses below the base; anything >= 32 above it is outside.
   assign w_off_full = {1'b0, s_ctrlport_req_addr} - {1'b0, BASE_ADDR};
   assign w_in_win   = (w_off_full[20:5] == 16'h0);
   assign w_off      = w_off_full[4:0];
   assign w_wr       = s_ctrlport_req_wr && w_in_win;
   assign w_rd       = s_ctrlport_req_rd && w_in_win;

   assign w_wr_gain = w_wr && (w_off == 5'h00);
   assign w_wr_tslo = w_wr && (w_off == 5'h04);
   assign w_wr_tshi = w_wr && (w_off == 5'h08);
   assign w_push    = w_wr && (w_off == 5'h0C);
   assign w_wr_stat = w_wr && (w_off == 5'h10);
   assign w_flush   = w_wr_stat && s_ctrlport_req_data[0];
   assign w_clr     = w_wr_stat && s_ctrlport_req_data[1];

   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == CNT_FULL);
   assign w_head_ts   = r_ts_mem[r_rd_ptr];
   assign w_head_gain = r_gain_mem[r_rd_ptr];

   // Immediate writes and flushes both suppress a due pop; the head waits for another strobe.
   assign w_due     = i_time_stb && !w_empty && (w_head_ts <= i_time);
   assign w_pop     = w_due && !w_wr_gain && !w_flush;
   assign w_late    = w_pop && (w_head_ts < i_time);
   // A full queue still takes the push when the head leaves in the same cycle.
   assign w_push_ok = w_push && (w_flush || !w_full || w_pop);

   assign w_status = {r_late, 7'b0, r_overflow, 6'b0, w_full, w_empty, 8'(r_count)};

   always_comb begin
      w_rdata = 32'h0;
      unique case (w_off)
         5'h00:   w_rdata = 32'(r_gain);
         5'h10:   w_rdata = w_status;
         default: w_rdata = 32'h0;
      endcase
   end

   // Queue storage needs no reset; validity is tracked by the pointers and count.
   always_ff @(posedge ce_clk) begin
      if (w_push_ok) begin
         r_ts_mem[r_wr_ptr]   <= r_ts_stage;
         r_gain_mem[r_wr_ptr] <= s_ctrlport_req_data[GAIN_W-1:0];
      end
   end

   always_ff @(posedge ce_clk or posedge ce_rst) begin
      if (ce_rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_flush) begin
            // Drop everything queued; a simultaneous push lands as the only entry.
            r_rd_ptr <= r_wr_ptr;
            r_count  <= w_push_ok ? CNT_ONE : '0;
         end else begin
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            unique case ({w_push_ok, w_pop})
               2'b10:   r_count <= r_count + CNT_ONE;
               2'b01:   r_count <= r_count - CNT_ONE;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   always_ff @(posedge ce_clk or posedge ce_rst) begin
      if (ce_rst) begin
         r_ts_stage <= '0;
         r_overflow <= 1'b0;
         r_late     <= '0;
      end else begin
         if (w_wr_tslo) r_ts_stage[31:0]  <= s_ctrlport_req_data;
         if (w_wr_tshi) r_ts_stage[63:32] <= s_ctrlport_req_data;
         if (w_clr) begin
            r_overflow <= 1'b0;
            r_late     <= '0;
         end else begin
            if (w_push && !w_push_ok)       r_overflow <= 1'b1;
            if (w_late && (r_late != 8'hFF)) r_late     <= r_late + 8'd1;
         end
      end
   end

   always_ff @(posedge ce_clk or posedge ce_rst) begin
      if (ce_rst) begin
         r_gain     <= GAIN_INIT;
         r_gain_upd <= 1'b0;
         r_ack      <= 1'b0;
         r_rdata    <= '0;
      end else begin
         r_ack      <= w_wr || w_rd;
         r_rdata    <= w_rd ? w_rdata : 32'h0;
         r_gain_upd <= w_wr_gain || w_pop;
         if (w_wr_gain) begin
            r_gain <= s_ctrlport_req_data[GAIN_W-1:0];
         end else if (w_pop) begin
            r_gain <= w_head_gain;
         end
      end
   end

   assign s_ctrlport_resp_ack  = r_ack;
   assign s_ctrlport_resp_data = r_rdata;
   assign o_gain               = r_gain;
   assign o_gain_upd           = r_gain_upd;

endmodule

// File: tb/tb_gain_oot_cmd_sched.sv
// Directed bench for gain_oot_cmd_sched: a table of single-cycle operations with
// hand-computed expected ack / gain / read data, followed by hand-written multi-cycle
// sequences for ack and update pulse width, pop/write conflicts and mid-queue reset.
module tb_gain_oot_cmd_sched;

   localparam int OP_WR     = 0;
   localparam int OP_RD     = 1;
   localparam int OP_STB    = 2;
   localparam int OP_STB_WR = 3;

   typedef struct {
      int          op;
      logic [19:0] addr;
      logic [31:0] data;
      logic [63:0] t;
      logic        exp_ack;
      logic [15:0] exp_gain;
      logic        chk_rd;
      logic [31:0] exp_rd;
      string       name;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_wr, req_rd;
   logic [19:0] req_addr;
   logic [31:0] req_data;
   logic        resp_ack;
   logic [31:0] resp_data;
   logic [63:0] tm;
   logic        tm_stb;
   logic [15:0] gain;
   logic        gain_upd;

   int n_vec = 0;
   int n_err = 0;

   logic        s_ack, s_upd;
   logic [15:0] s_gain;
   logic [31:0] s_rd;

   vec_t vecs[$];

   always #5 clk = ~clk;

   gain_oot_cmd_sched dut (
      .ce_clk               (clk),
      .ce_rst               (rst),
      .s_ctrlport_req_wr    (req_wr),
      .s_ctrlport_req_rd    (req_rd),
      .s_ctrlport_req_addr  (req_addr),
      .s_ctrlport_req_data  (req_data),
      .s_ctrlport_resp_ack  (resp_ack),
      .s_ctrlport_resp_data (resp_data),
      .i_time               (tm),
      .i_time_stb           (tm_stb),
      .o_gain               (gain),
      .o_gain_upd           (gain_upd)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Drive one operation for one cycle, then sample outputs on the following falling edge.
   task automatic do_op(input int op, input logic [19:0] a, input logic [31:0] d,
                        input logic [63:0] t);
      @(negedge clk);
      req_addr = a;
      req_data = d;
      tm       = t;
      req_wr   = (op == OP_WR) || (op == OP_STB_WR);
      req_rd   = (op == OP_RD);
      tm_stb   = (op == OP_STB) || (op == OP_STB_WR);
      @(negedge clk);
      s_ack  = resp_ack;
      s_upd  = gain_upd;
      s_gain = gain;
      s_rd   = resp_data;
      req_wr = 1'b0;
      req_rd = 1'b0;
      tm_stb = 1'b0;
   endtask

   task automatic add(input int op, input logic [19:0] a, input logic [31:0] d,
                      input logic [63:0] t, input logic eack, input logic [15:0] eg,
                      input logic chk, input logic [31:0] erd, input string nm);
      vec_t v;
      v.op = op; v.addr = a; v.data = d; v.t = t; v.exp_ack = eack;
      v.exp_gain = eg; v.chk_rd = chk; v.exp_rd = erd; v.name = nm;
      vecs.push_back(v);
   endtask

   task automatic wr(input logic [19:0] a, input logic [31:0] d);
      do_op(OP_WR, a, d, 64'h0);
   endtask

   initial begin
      rst      = 1'b1;
      req_wr   = 1'b0;
      req_rd   = 1'b0;
      req_addr = '0;
      req_data = '0;
      tm       = '0;
      tm_stb   = 1'b0;

      // Readback and register behaviour after the hand-written tests 1 and 2.
      add(OP_RD, 20'h00, 0, 0, 1, 16'h0200, 1, 32'h0000_0200, "rd_gain");
      // Single timed command released exactly at its timestamp.
      add(OP_WR, 20'h04, 100, 0, 1, 16'h0200, 0, 0, "ts_lo_100");
      add(OP_WR, 20'h08, 0, 0, 1, 16'h0200, 0, 0, "ts_hi_0");
      add(OP_WR, 20'h0C, 32'h0300, 0, 1, 16'h0200, 0, 0, "push_300");
      add(OP_RD, 20'h10, 0, 0, 1, 16'h0200, 1, 32'h0000_0001, "stat_cnt1");
      add(OP_STB, 0, 0, 98, 0, 16'h0200, 0, 0, "stb_98");
      add(OP_STB, 0, 0, 99, 0, 16'h0200, 0, 0, "stb_99");
      add(OP_STB, 0, 0, 100, 0, 16'h0300, 0, 0, "stb_100");
      add(OP_RD, 20'h10, 0, 0, 1, 16'h0300, 1, 32'h0000_0100, "stat_ontime");
      // Late release.
      add(OP_WR, 20'h04, 50, 0, 1, 16'h0300, 0, 0, "ts_lo_50");
      add(OP_WR, 20'h0C, 32'h0350, 0, 1, 16'h0300, 0, 0, "push_350");
      add(OP_STB, 0, 0, 60, 0, 16'h0350, 0, 0, "stb_60_late");
      add(OP_RD, 20'h10, 0, 0, 1, 16'h0350, 1, 32'h0100_0100, "stat_late1");
      // Flush with three queued.
      add(OP_WR, 20'h04, 1000, 0, 1, 16'h0350, 0, 0, "ts_lo_1000");
      add(OP_WR, 20'h0C, 32'h0361, 0, 1, 16'h0350, 0, 0, "push_361");
      add(OP_WR, 20'h0C, 32'h0362, 0, 1, 16'h0350, 0, 0, "push_362");
      add(OP_WR, 20'h0C, 32'h0363, 0, 1, 16'h0350, 0, 0, "push_363");
      add(OP_RD, 20'h10, 0, 0, 1, 16'h0350, 1, 32'h0100_0003, "stat_cnt3");
      add(OP_WR, 20'h10, 32'h1, 0, 1, 16'h0350, 0, 0, "flush");
      add(OP_RD, 20'h10, 0, 0, 1, 16'h0350, 1, 32'h0100_0100, "stat_flushed");
      add(OP_STB, 0, 0, 2000, 0, 16'h0350, 0, 0, "stb_after_flush");
      add(OP_WR, 20'h10, 32'h2, 0, 1, 16'h0350, 0, 0, "clr_late");
      add(OP_RD, 20'h10, 0, 0, 1, 16'h0350, 1, 32'h0000_0100, "stat_cleared");
      // Overflow: nine pushes into eight slots, far-future timestamps.
      add(OP_WR, 20'h08, 1, 0, 1, 16'h0350, 0, 0, "ts_hi_1");
      for (int i = 1; i <= 9; i++)
         add(OP_WR, 20'h0C, 32'h0400 + i, 0, 1, 16'h0350, 0, 0, $sformatf("push_ovf%0d", i));
      add(OP_RD, 20'h10, 0, 0, 1, 16'h0350, 1, 32'h0001_0208, "stat_full_ovf");
      add(OP_WR, 20'h10, 32'h2, 0, 1, 16'h0350, 0, 0, "clr_ovf");
      add(OP_RD, 20'h10, 0, 0, 1, 16'h0350, 1, 32'h0000_0208, "stat_ovf_clr");
      // Drain in FIFO order, one per strobe, all late.
      for (int i = 1; i <= 8; i++)
         add(OP_STB, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 16'h0400 + 16'(i), 0, 0,
             $sformatf("drain%0d", i));
      add(OP_STB, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 16'h0408, 0, 0, "no_ninth");
      add(OP_RD, 20'h10, 0, 0, 1, 16'h0408, 1, 32'h0800_0100, "stat_drained");
      // Unmapped offsets and out-of-window accesses.
      add(OP_WR, 20'h14, 32'h55, 0, 1, 16'h0408, 0, 0, "wr_unmapped");
      add(OP_RD, 20'h14, 0, 0, 1, 16'h0408, 1, 32'h0, "rd_unmapped");
      add(OP_WR, 20'h20, 32'h0999, 0, 0, 16'h0408, 0, 0, "wr_outside");
      add(OP_RD, 20'h20, 0, 0, 0, 16'h0408, 1, 32'h0, "rd_outside");

      // Reset state.
      repeat (2) @(negedge clk);
      check("reset_gain", 64'(gain), 64'h1);
      check("reset_upd", 64'(gain_upd), 64'h0);
      check("reset_ack", 64'(resp_ack), 64'h0);
      rst = 1'b0;

      // Test 1: status read after reset, ack exactly one cycle.
      do_op(OP_RD, 20'h10, 0, 0);
      check("t1_ack", 64'(s_ack), 64'h1);
      check("t1_rdata", 64'(s_rd), 64'h100);
      @(negedge clk);
      check("t1_ack_end", 64'(resp_ack), 64'h0);

      // Test 2: immediate write with a single update pulse.
      wr(20'h00, 32'h0200);
      check("t2_ack", 64'(s_ack), 64'h1);
      check("t2_gain", 64'(s_gain), 64'h0200);
      check("t2_upd", 64'(s_upd), 64'h1);
      @(negedge clk);
      check("t2_upd_end", 64'(gain_upd), 64'h0);
      check("t2_ack_end", 64'(resp_ack), 64'h0);

      foreach (vecs[i]) begin
         do_op(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].t);
         check({vecs[i].name, "_ack"}, 64'(s_ack), 64'(vecs[i].exp_ack));
         check({vecs[i].name, "_gain"}, 64'(s_gain), 64'(vecs[i].exp_gain));
         if (vecs[i].chk_rd) check({vecs[i].name, "_rd"}, 64'(s_rd), 64'(vecs[i].exp_rd));
      end

      // Immediate write beats a due pop; the head waits for the next strobe.
      wr(20'h08, 0);
      wr(20'h04, 10);
      wr(20'h0C, 32'h0500);
      do_op(OP_STB_WR, 20'h00, 32'h0400, 20);
      check("conf_wr_gain", 64'(s_gain), 64'h0400);
      check("conf_wr_upd", 64'(s_upd), 64'h1);
      do_op(OP_RD, 20'h10, 0, 0);
      check("conf_wr_cnt", 64'(s_rd[7:0]), 64'h1);
      do_op(OP_STB, 0, 0, 20);
      check("conf_next_pop", 64'(s_gain), 64'h0500);

      // Flush beats a due pop; o_gain stays put.
      wr(20'h04, 5);
      wr(20'h0C, 32'h0600);
      do_op(OP_STB_WR, 20'h10, 32'h1, 10);
      check("flush_pop_gain", 64'(s_gain), 64'h0500);
      check("flush_pop_upd", 64'(s_upd), 64'h0);
      do_op(OP_RD, 20'h10, 0, 0);
      check("flush_pop_cnt", 64'(s_rd[9:0]), 64'h100);
      do_op(OP_STB, 0, 0, 10);
      check("flush_pop_after", 64'(s_gain), 64'h0500);

      // Push into a full queue while the head pops: accepted, count unchanged, no overflow.
      for (int i = 1; i <= 8; i++) wr(20'h0C, 32'h0700 + i);
      do_op(OP_STB_WR, 20'h0C, 32'h0709, 10);
      check("full_pp_gain", 64'(s_gain), 64'h0701);
      do_op(OP_RD, 20'h10, 0, 0);
      check("full_pp_stat", 64'(s_rd[16:0]), 64'h0208);

      // Asynchronous reset mid-queue.
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_gain", 64'(gain), 64'h1);
      @(negedge clk);
      rst = 1'b0;
      do_op(OP_RD, 20'h10, 0, 0);
      check("rst_mid_stat", 64'(s_rd), 64'h100);
      do_op(OP_STB, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
      check("rst_mid_nopop", 64'(s_gain), 64'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
